// File: rtl/design_mux_pkg.sv
// Shared types, default parameter values and bus helpers for the design-selection mux.
package design_mux_pkg;

  localparam int unsigned DEF_NUM_DESIGNS   = 16;
  localparam int unsigned DEF_OUT_WIDTH     = 8;
  localparam int unsigned DEF_SEL_WIDTH     = 4;
  localparam int unsigned DEF_STABLE_CYCLES = 4;
  localparam int unsigned DEF_BLANK_CYCLES  = 8;
  localparam int unsigned DEF_SAFE_VALUE    = 0;

  // Upper bounds for the generic slice helper; the caller truncates the result.
  localparam int unsigned SLICE_BUS_MAX = 4096;
  localparam int unsigned SLICE_OUT_MAX = 256;

  typedef enum logic [1:0] {
    ST_ACTIVE   = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_BLANK    = 2'd2
  } state_e;

  // Returns slice idx of width 'width' from a flattened bus (LSB-aligned).
  function automatic logic [SLICE_OUT_MAX-1:0] get_slice(
    input logic [SLICE_BUS_MAX-1:0] bus,
    input int unsigned              idx,
    input int unsigned              width
  );
    logic [SLICE_BUS_MAX-1:0] shifted;
    shifted = bus >> (idx * width);
    return shifted[SLICE_OUT_MAX-1:0];
  endfunction

endpackage

// File: rtl/design_mux_sync_2ff.sv
// Parametrised-width two-flop synchroniser with asynchronous active-low reset.
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/design_mux.sv
// Glitch-free design-selection mux: synchronised, debounced and blanked select
// changes, with non-selected designs held in reset.
module design_mux
  import design_mux_pkg::*;
#(
  parameter int unsigned          NUM_DESIGNS   = DEF_NUM_DESIGNS,
  parameter int unsigned          OUT_WIDTH     = DEF_OUT_WIDTH,
  parameter int unsigned          SEL_WIDTH     = DEF_SEL_WIDTH,
  parameter int unsigned          STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int unsigned          BLANK_CYCLES  = DEF_BLANK_CYCLES,
  parameter logic [OUT_WIDTH-1:0] SAFE_VALUE    = OUT_WIDTH'(DEF_SAFE_VALUE)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [SEL_WIDTH-1:0]           design_sel_in,
  input  logic [NUM_DESIGNS*OUT_WIDTH-1:0] design_outs_in,
  output logic [OUT_WIDTH-1:0]           mux_out,
  output logic [NUM_DESIGNS-1:0]         design_rst_n_out,
  output logic [SEL_WIDTH-1:0]           active_sel_out,
  output logic                           sel_valid_out,
  output logic                           switching_out
);

  localparam int unsigned CNT_MAX = (STABLE_CYCLES > BLANK_CYCLES) ? STABLE_CYCLES : BLANK_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  logic [SEL_WIDTH-1:0] sel_sync;

  state_e               state, state_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic [SEL_WIDTH-1:0] cand, cand_nxt;
  logic [SEL_WIDTH-1:0] active_sel, active_nxt;

  logic [OUT_WIDTH-1:0]   mux_nxt;
  logic [NUM_DESIGNS-1:0] rstn_nxt;
  logic                   valid_nxt;
  logic                   switching_nxt;

  logic                   cur_valid;
  logic                   routed;
  logic [OUT_WIDTH-1:0]   active_slice;

  sync_2ff #(
    .WIDTH (SEL_WIDTH)
  ) u_sel_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (design_sel_in),
    .q     (sel_sync)
  );

  assign active_slice   = OUT_WIDTH'(get_slice(SLICE_BUS_MAX'(design_outs_in),
                                               32'(active_sel), OUT_WIDTH));
  assign cur_valid      = 32'(active_sel) < NUM_DESIGNS;
  // Old design keeps driving through DEBOUNCE; only BLANK cuts it off.
  assign routed         = (state != ST_BLANK) && cur_valid;
  assign active_sel_out = active_sel;

  // State, counter and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= ST_BLANK;
      cnt              <= CNT_W'(1);
      cand             <= '0;
      active_sel       <= '0;
      mux_out          <= SAFE_VALUE;
      design_rst_n_out <= '0;
      sel_valid_out    <= 1'b1;
      switching_out    <= 1'b1;
    end else begin
      state            <= state_nxt;
      cnt              <= cnt_nxt;
      cand             <= cand_nxt;
      active_sel       <= active_nxt;
      mux_out          <= mux_nxt;
      design_rst_n_out <= rstn_nxt;
      sel_valid_out    <= valid_nxt;
      switching_out    <= switching_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    cand_nxt   = cand;
    active_nxt = active_sel;
    mux_nxt    = SAFE_VALUE;
    rstn_nxt   = '0;

    case (state)
      ST_ACTIVE: begin
        if (sel_sync != active_sel) begin
          state_nxt = ST_DEBOUNCE;
          cand_nxt  = sel_sync;
          cnt_nxt   = CNT_W'(1);
        end
      end
      ST_DEBOUNCE: begin
        if (sel_sync == active_sel) begin
          state_nxt = ST_ACTIVE;
        end else if (sel_sync != cand) begin
          cand_nxt = sel_sync;
          cnt_nxt  = CNT_W'(1);
        end else if (cnt == CNT_W'(STABLE_CYCLES)) begin
          state_nxt  = ST_BLANK;
          active_nxt = cand;
          cnt_nxt    = CNT_W'(1);
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ST_BLANK: begin
        if (cnt == CNT_W'(BLANK_CYCLES)) begin
          state_nxt = ST_ACTIVE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = ST_BLANK;
        cnt_nxt   = CNT_W'(1);
      end
    endcase

    if (routed) begin
      mux_nxt = active_slice;
    end
    for (int unsigned i = 0; i < NUM_DESIGNS; i++) begin
      rstn_nxt[i] = routed && (32'(active_sel) == i);
    end
    valid_nxt     = 32'(active_nxt) < NUM_DESIGNS;
    switching_nxt = (state_nxt != ST_ACTIVE);
  end

endmodule
